mem_bridge: RTL and testbench
=============================

MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 Parameter ADDR_W, default 32: width of the address bus on both sides.
REQ-002 Parameter DATA_W, default 32: width of the data bus on both sides.
REQ-003 Parameter TIMEOUT, default 255: maximum number of cycles in REQ without bus_ack; legal range 1..255.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 mem_read  input  1  read request from the control FSM, held high until mem_resp.
REQ-007 mem_write  input  1  write request from the control FSM, held high until mem_resp.
REQ-008 mem_addr  input  ADDR_W  byte address; taken from MAR.
REQ-009 mem_wdata  input  DATA_W  write data; taken from MDR.
REQ-010 mem_be  input  DATA_W/8  byte enables for writes.
REQ-011 mem_rdata  output  DATA_W  read data to MDR; valid in the mem_resp cycle.
REQ-012 mem_resp  output  1  one-cycle completion pulse.
REQ-013 mem_err  output  1  completion was a timeout; valid in the mem_resp cycle.
REQ-014 bus_req  output  1  request to the backing memory.
REQ-015 bus_we  output  1  1 = write, 0 = read.
REQ-016 bus_addr  output  ADDR_W  word-aligned address, {addr[ADDR_W-1:2], 2'b00}.
REQ-017 bus_wdata  output  DATA_W  latched write data.
REQ-018 bus_be  output  DATA_W/8  latched byte enables; forced to all ones on reads.
REQ-019 bus_ack  input  1  memory completion; sampled only in REQ.
REQ-020 bus_rdata  input  DATA_W  read data; valid in the bus_ack cycle.

Function
REQ-021 The FSM SHALL have four states: IDLE, REQ, RESP and HOLD.
REQ-022 IDLE: when (mem_read | mem_write) = 1, latch addr, wdata, be and we (= mem_write), clear the timeout counter, and go to REQ.
REQ-023 If mem_read and mem_write are both high in IDLE, the write SHALL win (bus_we = 1).
REQ-024 REQ: bus_req = 1, with bus_we/addr/wdata/be driven from the latches and held stable.
REQ-025 REQ with bus_ack = 1: capture bus_rdata into mem_rdata (0 for writes), set mem_err = 0, go to RESP.
REQ-026 REQ without bus_ack: increment the counter; when it reaches TIMEOUT-1, go to RESP with mem_err = 1 and mem_rdata = 0.
REQ-027 If bus_ack arrives in the same cycle as the timeout, the ack SHALL win and mem_err = 0.
REQ-028 RESP: mem_resp = 1 for exactly one cycle and bus_req = 0, then go to HOLD.
REQ-029 HOLD: stay while (mem_read | mem_write) = 1, then go to IDLE; no new request is accepted until the FSM returns to IDLE.
REQ-030 mem_rdata and mem_err SHALL hold their values until the next RESP.
REQ-031 bus_ack outside REQ SHALL be ignored.
REQ-032 Latency: request first seen in IDLE at cycle N, bus_req high at N+1; bus_ack at cycle M, mem_resp at M+1; minimum round trip is 2 cycles.

Reset
REQ-033 rst = 1 SHALL immediately force IDLE, counter = 0, all outputs = 0, and all latches = 0, regardless of clk.
REQ-034 Reset asserted mid-transaction SHALL abort it: bus_req drops asynchronously and no mem_resp is produced.
REQ-035 After rst deasserts, a request that is still held SHALL be accepted on the next IDLE edge.

Verification
REQ-036 Read: mem_read = 1, addr = 0x0000_0104, ack 3 cycles later with rdata = 0xDEAD_BEEF -> bus_addr = 0x104, bus_we = 0, bus_be = 0xF, mem_resp 1 cycle with rdata = 0xDEADBEEF, mem_err = 0.
REQ-037 Write, be = 0x3, wdata = 0x1234_5678, ack in the first REQ cycle -> bus_we = 1, bus_be = 0x3, mem_resp exactly 2 cycles after the request.
REQ-038 Timeout: TIMEOUT = 4, no ack -> bus_req high for 4 cycles, then mem_resp with mem_err = 1 and rdata = 0; an ack coincident with the 4th cycle gives mem_err = 0.
REQ-039 Held request: mem_read stays high for 3 cycles after mem_resp -> exactly one bus transaction, and a second mem_resp occurs only after a deassert-then-reassert.
REQ-040 Async reset pulse mid-REQ with no clk edge -> bus_req = 0 immediately, no mem_resp, and the state is IDLE afterwards.
REQ-041 mem_read and mem_write both high in IDLE -> bus_we = 1.

Source files
------------

// File: rtl/mem_bridge_if.sv
// Bundles the control-FSM request side and the backing-memory bus side of mem_bridge.
// master: the requester plus memory (drives requests and acks); slave: the bridge itself.
interface mem_bridge_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_resp;
    logic              mem_err;

    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [BE_W-1:0]   bus_be;
    logic              bus_ack;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        output mem_read, mem_write, mem_addr, mem_wdata, mem_be, bus_ack, bus_rdata,
        input  mem_rdata, mem_resp, mem_err, bus_req, bus_we, bus_addr, bus_wdata, bus_be
    );

    modport slave (
        input  mem_read, mem_write, mem_addr, mem_wdata, mem_be, bus_ack, bus_rdata,
        output mem_rdata, mem_resp, mem_err, bus_req, bus_we, bus_addr, bus_wdata, bus_be
    );
endinterface

// File: rtl/mem_bridge.sv
// Converts held-level memory requests into a single bus transaction with ack/timeout,
// returning a one-cycle completion pulse with read data and an error flag.
module mem_bridge #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input logic        clk,
    input logic        rst,
    mem_bridge_if.slave mb
);
    localparam int unsigned BE_W = DATA_W / 8;

    typedef enum logic [1:0] {StIdle, StReq, StResp, StHold} state_e;

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic req_any;
    logic timed_out;
    logic accept;

    assign req_any   = mb.mem_read | mb.mem_write;
    assign timed_out = (cnt_q == 8'(TIMEOUT - 1));
    assign accept    = (state_q == StIdle) && req_any;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (req_any) state_d = StReq;
            StReq:   if (mb.bus_ack || timed_out) state_d = StResp;
            StResp:  state_d = StHold;
            StHold:  if (!req_any) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Request latches, timeout counter and completion results
    always_comb begin
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        if (accept) begin
            // Write wins when both requests are high; reads always use all byte lanes.
            we_d    = mb.mem_write;
            addr_d  = mb.mem_addr & ~ADDR_W'(3);
            wdata_d = mb.mem_wdata;
            be_d    = mb.mem_write ? mb.mem_be : {BE_W{1'b1}};
            cnt_d   = '0;
        end

        if (state_q == StReq) begin
            if (mb.bus_ack) begin
                rdata_d = we_q ? '0 : mb.bus_rdata;
                err_d   = 1'b0;
            end else if (timed_out) begin
                rdata_d = '0;
                err_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Outputs decoded from state so reset clears them without waiting for a clock edge
    always_comb begin
        mb.bus_req   = (state_q == StReq);
        mb.mem_resp  = (state_q == StResp);
        mb.bus_we    = we_q;
        mb.bus_addr  = addr_q;
        mb.bus_wdata = wdata_q;
        mb.bus_be    = be_q;
        mb.mem_rdata = rdata_q;
        mb.mem_err   = err_q;
    end

endmodule

// File: tb/tb_mem_bridge.sv
// Self-checking bench for mem_bridge: directed vector table, randomized transactions
// against a transaction-level model, and asynchronous reset sequences.
module tb_mem_bridge;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int TMO = 4;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          ack_dly;   // REQ cycle index (0-based) carrying the ack; -1 = never
        logic [31:0] rdata;
        int          hold;      // extra cycles the request stays high after completion
        logic        exp_we;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        int          exp_req;   // cycles with bus_req high
        int          exp_lat;   // cycles from request to mem_resp
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();

    mem_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .mb  (bif)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Transaction-level expectation derived from the ack/timeout rules.
    function automatic vec_t model(input logic rd, input logic wr, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [3:0] be,
                                   input int ack_dly, input logic [31:0] rdata, input int hold);
        vec_t v;
        logic acked;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.be = be;
        v.ack_dly = ack_dly; v.rdata = rdata; v.hold = hold;
        acked       = (ack_dly >= 0) && (ack_dly < TMO);
        v.exp_we    = wr;
        v.exp_addr  = {addr[31:2], 2'b00};
        v.exp_be    = wr ? be : 4'hF;
        v.exp_req   = acked ? ack_dly + 1 : TMO;
        v.exp_lat   = v.exp_req + 1;
        v.exp_err   = !acked;
        v.exp_rdata = (acked && !wr) ? rdata : 32'h0;
        return v;
    endfunction

    // Called at a negedge with the bridge idle; returns at a negedge with the bridge idle.
    task automatic run_txn(input vec_t v, input string tag);
        int  req_n = 0;
        int  lat   = 0;
        bit  done  = 0;
        bif.mem_read  = v.rd;
        bif.mem_write = v.wr;
        bif.mem_addr  = v.addr;
        bif.mem_wdata = v.wdata;
        bif.mem_be    = v.be;
        bif.bus_rdata = v.rdata;
        bif.bus_ack   = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            lat++;
            bif.bus_ack = 1'b0;
            if (bif.mem_resp) begin
                done = 1;
            end else if (bif.bus_req) begin
                if (req_n == 0) begin
                    check({tag, " bus_we"},    bif.bus_we,    v.exp_we);
                    check({tag, " bus_addr"},  bif.bus_addr,  v.exp_addr);
                    check({tag, " bus_be"},    bif.bus_be,    v.exp_be);
                    check({tag, " bus_wdata"}, bif.bus_wdata, v.wdata);
                end
                bif.bus_ack = (req_n == v.ack_dly);
                req_n++;
            end
        end
        check({tag, " resp_seen"}, done, 1'b1);
        check({tag, " req_cycles"}, req_n, v.exp_req);
        check({tag, " latency"}, lat, v.exp_lat);
        check({tag, " mem_err"}, bif.mem_err, v.exp_err);
        check({tag, " mem_rdata"}, bif.mem_rdata, v.exp_rdata);
        // Acks outside REQ must be ignored; results must persist while the request is held.
        bif.bus_ack = 1'b1;
        for (int h = 0; h <= v.hold; h++) begin
            @(negedge clk);
            check({tag, " hold_resp"}, bif.mem_resp, 1'b0);
            check({tag, " hold_req"}, bif.bus_req, 1'b0);
            check({tag, " hold_rdata"}, bif.mem_rdata, v.exp_rdata);
        end
        bif.bus_ack   = 1'b0;
        bif.mem_read  = 1'b0;
        bif.mem_write = 1'b0;
        @(negedge clk);
        check({tag, " idle_req"}, bif.bus_req, 1'b0);
    endtask

    vec_t tbl[8];

    initial begin
        tbl[0] = '{1, 0, 32'h0000_0104, 32'h0, 4'h0, 2, 32'hDEAD_BEEF, 0,
                   0, 32'h0000_0104, 4'hF, 3, 4, 0, 32'hDEAD_BEEF};
        tbl[1] = '{0, 1, 32'h2000_0007, 32'h1234_5678, 4'h3, 0, 32'hAAAA_5555, 0,
                   1, 32'h2000_0004, 4'h3, 1, 2, 0, 32'h0};
        tbl[2] = '{1, 0, 32'h0000_0010, 32'h0, 4'h0, -1, 32'h1111_1111, 0,
                   0, 32'h0000_0010, 4'hF, 4, 5, 1, 32'h0};
        tbl[3] = '{1, 0, 32'h0000_0011, 32'h0, 4'h0, 3, 32'hCAFE_F00D, 0,
                   0, 32'h0000_0010, 4'hF, 4, 5, 0, 32'hCAFE_F00D};
        tbl[4] = '{1, 1, 32'h0000_0003, 32'h0BAD_C0DE, 4'h9, 1, 32'h7777_7777, 0,
                   1, 32'h0000_0000, 4'h9, 2, 3, 0, 32'h0};
        tbl[5] = '{1, 0, 32'hFFFF_FFFE, 32'h0, 4'h0, 0, 32'h5A5A_5A5A, 3,
                   0, 32'hFFFF_FFFC, 4'hF, 1, 2, 0, 32'h5A5A_5A5A};
        tbl[6] = '{1, 0, 32'hFFFF_FFFE, 32'h0, 4'h0, 4, 32'h0102_0304, 0,
                   0, 32'hFFFF_FFFC, 4'hF, 4, 5, 1, 32'h0};
        tbl[7] = '{0, 1, 32'h8000_0000, 32'hFFFF_0000, 4'h0, -1, 32'h0, 1,
                   1, 32'h8000_0000, 4'h0, 4, 5, 1, 32'h0};

        rst = 1'b1;
        bif.mem_read = 0; bif.mem_write = 0; bif.mem_addr = 0; bif.mem_wdata = 0;
        bif.mem_be = 0; bif.bus_ack = 0; bif.bus_rdata = 0;
        repeat (2) @(negedge clk);
        check("reset bus_req", bif.bus_req, 1'b0);
        check("reset mem_resp", bif.mem_resp, 1'b0);
        check("reset outputs", {bif.bus_we, bif.bus_addr, bif.bus_be, bif.mem_err}, 64'h0);
        check("reset data", {bif.bus_wdata, bif.mem_rdata}, 64'h0);
        rst = 1'b0;
        @(negedge clk);

        // Stray acks while idle must not start anything.
        bif.bus_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_ack bus_req", bif.bus_req, 1'b0);
            check("idle_ack mem_resp", bif.mem_resp, 1'b0);
        end
        bif.bus_ack = 1'b0;

        foreach (tbl[i]) run_txn(tbl[i], $sformatf("vec%0d", i));

        for (int n = 0; n < 40; n++) begin
            int   sel = int'($urandom_range(0, 2));
            int   d   = int'($urandom_range(0, 6));
            vec_t v;
            if (d == 6) d = -1;
            v = model(sel != 1, sel != 0, $urandom, $urandom, 4'($urandom), d, $urandom,
                      int'($urandom_range(0, 2)));
            run_txn(v, $sformatf("rnd%0d", n));
        end

        // Reset mid-REQ with the request still held: abort, then re-accept.
        run_txn(tbl[0], "pre_rst");
        bif.mem_read = 1; bif.mem_write = 0; bif.mem_addr = 32'h40; bif.bus_rdata = 32'h77;
        @(negedge clk);
        check("rst1 pre bus_req", bif.bus_req, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rst1 async bus_req", bif.bus_req, 1'b0);
        check("rst1 async rdata", bif.mem_rdata, 32'h0);
        check("rst1 async resp", bif.mem_resp, 1'b0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst1 reaccept bus_req", bif.bus_req, 1'b1);
        bif.bus_ack = 1'b1;
        @(negedge clk);
        bif.bus_ack = 1'b0;
        check("rst1 resp", bif.mem_resp, 1'b1);
        check("rst1 rdata", bif.mem_rdata, 32'h77);
        bif.mem_read = 0;
        repeat (2) @(negedge clk);

        // Reset mid-REQ with the request dropped: no completion may follow.
        bif.mem_read = 1;
        @(negedge clk);
        check("rst2 pre bus_req", bif.bus_req, 1'b1);
        #2 rst = 1'b1;
        bif.mem_read = 0;
        #1;
        check("rst2 async bus_req", bif.bus_req, 1'b0);
        #1 rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("rst2 no bus_req", bif.bus_req, 1'b0);
            check("rst2 no resp", bif.mem_resp, 1'b0);
        end
        run_txn(tbl[1], "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
